// File: rtl/mux4_arbiter_if.sv
// mux4_arbiter_if: request/grant bundle between the requesters and the mux arbiter
interface mux4_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;
  modport master (input req, output gnt, sel, valid, timeout);
  modport slave (output req, input gnt, sel, valid, timeout);
endinterface

// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin owner of the shared 4:1 mux select; define MUX4_ARB_TIMEOUT_EN to cap grants at HOLD_MAX cycles
module mux4_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input logic clk,
  input logic rst,
  mux4_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, sel_q, sel_n, idx, pick;
  logic [3:0] gnt_q, gnt_n;
  logic [7:0] dbl;
  logic valid_q, valid_n, timeout_q, timeout_n, own, force_rel;
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("HOLD_MAX must be within 1..255");
  end
`ifdef MUX4_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;
  // hold counter: zero outside GRANT, saturating count of held cycles inside it
  always_comb cnt_n = state != GRANT ? 8'd0 : cnt == 8'hff ? cnt : cnt + 8'd1;
  // hold counter register
  always_ff @(posedge clk) cnt <= rst ? 8'd0 : cnt_n;
  assign force_rel = own && cnt == 8'(HOLD_MAX - 1);
`else
  assign force_rel = 1'b0;
`endif
  assign own = bus.req[sel_q];
  assign bus.gnt = gnt_q;
  assign bus.sel = sel_q;
  assign bus.valid = valid_q;
  assign bus.timeout = timeout_q;
  // next state: rotate requests so ptr sits at bit 0, take lowest set bit, then undo rotation
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) if (dbl[k]) idx = 2'(k);
    pick = ptr + idx;
    state_n = state;
    ptr_n = ptr;
    gnt_n = gnt_q;
    sel_n = sel_q;
    valid_n = valid_q;
    timeout_n = 1'b0;
    if (state == GRANT) begin
      if (!own || force_rel) begin
        gnt_n = 4'd0;
        valid_n = 1'b0;
        ptr_n = sel_q + 2'd1;
        timeout_n = force_rel;
        state_n = RELEASE;
      end
    end else if (|bus.req) begin
      gnt_n = 4'b0001 << pick;
      sel_n = pick;
      valid_n = 1'b1;
      state_n = GRANT;
    end else begin
      state_n = IDLE;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 2'd0;
      gnt_q <= 4'd0;
      sel_q <= 2'd0;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gnt_q <= gnt_n;
      sel_q <= sel_n;
      valid_q <= valid_n;
      timeout_q <= timeout_n;
    end
  end
endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed vectors with a queued scoreboard checking gnt/sel/valid/timeout each cycle
module tb_mux4_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  mux4_arbiter_if bus();
  mux4_arbiter #(.HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] s, input logic v, input logic t);
    @(negedge clk);
    rst = r;
    bus.req = rq;
    exp_q.push_back({g, s, v, t});
  endtask
  initial begin
    logic [7:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {bus.gnt, bus.sel, bus.valid, bus.timeout};
        checks++;
        if (got !== e)
          $display("FAIL out t=%0t got gnt=%b sel=%b valid=%b timeout=%b exp gnt=%b sel=%b valid=%b timeout=%b",
                   $time, got[7:4], got[3:2], got[1], got[0], e[7:4], e[3:2], e[1], e[0]);
        else passed++;
      end
    end
  end
  initial begin
    bus.req = 4'b0000;
    step(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    step(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    step(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    step(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    step(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
    step(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    step(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
    step(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] oh, drop;
      oh = 4'b0001 << (i % 4);
      drop = 4'b1111 & ~oh;
      step(0, 4'b1111, oh, 2'(i % 4), 1, 0);
      step(0, 4'b1111, oh, 2'(i % 4), 1, 0);
      step(0, 4'b1111, oh, 2'(i % 4), 1, 0);
      step(0, drop, 4'b0000, 2'(i % 4), 0, 0);
    end
    step(0, 4'b1001, 4'b1000, 2'd3, 1, 0);
    step(0, 4'b0001, 4'b0000, 2'd3, 0, 0);
    step(0, 4'b1001, 4'b0001, 2'd0, 1, 0);
    step(0, 4'b1000, 4'b0000, 2'd0, 0, 0);
    step(0, 4'b1001, 4'b1000, 2'd3, 1, 0);
    step(0, 4'b0000, 4'b0000, 2'd3, 0, 0);
    step(0, 4'b0000, 4'b0000, 2'd3, 0, 0);
    step(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    step(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    step(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    step(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    step(1, 4'b0000, 4'b0000, 2'd0, 0, 0);
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      repeat (4) step(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
      step(0, 4'b0011, 4'b0000, 2'd0, 0, 1);
      repeat (4) step(0, 4'b0011, 4'b0010, 2'd1, 1, 0);
      step(0, 4'b0011, 4'b0000, 2'd1, 0, 1);
    end
`else
    repeat (10) step(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
`endif
    step(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    repeat (4) step(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    step(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
